// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a framed, checksummed program image as a byte stream and
//            writes it into the instruction RAM, holding the processor in
//            reset until the image checks out. It then serves instruction
//            words to the processor from pc.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int BITNESS = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reload,
    input  logic [BITNESS-1:0] pc,
    output logic [15:0]        instruction,
    output logic               cpu_rst,
    output logic               loaded,
    output logic               error,
    output logic [ADDR_W:0]    count
);

    localparam int          DEPTH   = 2**ADDR_W;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    localparam logic [2:0] S_LEN_LO  = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_DATA_LO = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    logic [2:0]        state;
    logic [7:0]        len_lo;
    logic [7:0]        lo_byte;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       mem [DEPTH];

    logic              xfer;
    logic [15:0]       len_w;
    logic              last_word;
    logic [BITNESS-1:0] count_ext;

    assign in_ready  = (state <= S_CSUM) && !reload;
    assign xfer      = in_valid && in_ready;
    assign len_w     = {in_data, len_lo};
    assign last_word = ({1'b0, wr_addr} == (count - {{ADDR_W{1'b0}}, 1'b1}));
    assign loaded    = (state == S_RUN);
    assign error     = (state == S_ERROR);
    assign count_ext = BITNESS'(count);

    // Words past the current image length read as zero, even if the RAM
    // still holds data from an older or aborted image.
    assign instruction = (loaded && (pc < count_ext)) ? mem[pc[ADDR_W-1:0]] : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_LEN_LO;
            cpu_rst <= 1'b1;
            count   <= '0;
            wr_addr <= '0;
            csum    <= '0;
            len_lo  <= '0;
            lo_byte <= '0;
        end else if (reload) begin
            state   <= S_LEN_LO;
            cpu_rst <= 1'b1;
        end else begin
            // Lags state by one cycle so the processor leaves reset only
            // once the RAM is already being served.
            cpu_rst <= (state != S_RUN);
            if (xfer) begin
                case (state)
                    S_LEN_LO: begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if ((len_w == 16'h0000) || ({1'b0, len_w} > DEPTH_W)) begin
                            state <= S_ERROR;
                        end else begin
                            count   <= len_w[ADDR_W:0];
                            wr_addr <= '0;
                            csum    <= '0;
                            state   <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: begin
                        lo_byte <= in_data;
                        csum    <= csum ^ in_data;
                        state   <= S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        csum    <= csum ^ in_data;
                        state   <= last_word ? S_CSUM : S_DATA_LO;
                    end
                    S_CSUM: begin
                        state <= (in_data == csum) ? S_RUN : S_ERROR;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && xfer && (state == S_DATA_HI)) begin
            mem[wr_addr] <= {in_data, lo_byte};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Scoreboard bench for program_loader: image words are queued as
//            they are streamed in and compared against instruction reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int BITNESS = 16;
    localparam int ADDR_W  = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               reload;
    logic [BITNESS-1:0] pc;
    logic [15:0]        instruction;
    logic               cpu_rst;
    logic               loaded;
    logic               error;
    logic [ADDR_W:0]    count;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] img [256];
    logic [15:0] exp_q [$];

    program_loader #(.BITNESS(BITNESS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .pc(pc),
        .instruction(instruction), .cpu_rst(cpu_rst), .loaded(loaded),
        .error(error), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        @(negedge clk);
        if (gaps) begin
            while ($urandom_range(1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_image(input int n, input logic [7:0] flip, input bit gaps);
        logic [15:0] len;
        logic [7:0]  cs;
        len = 16'(n);
        cs  = 8'h00;
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][7:0], gaps);
            send_byte(img[i][15:8], gaps);
            cs = cs ^ img[i][7:0] ^ img[i][15:8];
            if (flip == 8'h00) exp_q.push_back(img[i]);
        end
        send_byte(cs ^ flip, gaps);
    endtask

    task automatic pulse_reload(input logic [7:0] junk);
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = junk;
        #1 chk("ready_in_reload", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reload_ready", 32'(in_ready), 32'd1);
        chk("reload_loaded", 32'(loaded), 32'd0);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_error", 32'(error), 32'd0);
    endtask

    task automatic expect_run(input int n);
        @(negedge clk);
        chk("run_loaded", 32'(loaded), 32'd1);
        chk("run_cpu_rst_lag", 32'(cpu_rst), 32'd1);
        chk("run_ready", 32'(in_ready), 32'd0);
        chk("run_count", 32'(count), 32'(n));
        @(negedge clk);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        for (int i = 0; i < n; i++) begin
            pc = 16'(i);
            #1;
            if (exp_q.size() == 0) chk("queue_empty", 32'd1, 32'd0);
            else chk("ram_word", 32'(instruction), 32'(exp_q.pop_front()));
        end
        pc = 16'(n);
        #1 chk("pc_eq_count", 32'(instruction), 32'd0);
        pc = 16'h0100 + 16'(n % 256);
        #1 if (n < 256) chk("pc_high_bits", 32'(instruction), 32'd0);
    endtask

    task automatic expect_error(input string tag);
        @(negedge clk);
        chk({tag, "_error"}, 32'(error), 32'd1);
        chk({tag, "_loaded"}, 32'(loaded), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_sticky"}, 32'(error), 32'd1);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b0; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00; pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        rst = 1'b1;
        #1 chk("rst_ready", 32'(in_ready), 32'd1);

        // Reference three-word image
        img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h0F0F;
        send_image(3, 8'h00, 1'b0);
        expect_run(3);

        // Same image with a corrupted checksum
        pulse_reload(8'hFF);
        send_image(3, 8'h01, 1'b0);
        expect_error("csum");

        // Length boundaries
        pulse_reload(8'h03);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        expect_error("len0");
        pulse_reload(8'h01);
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
        expect_error("len257");

        // Full-depth image
        pulse_reload(8'h00);
        for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
        send_image(256, 8'h00, 1'b0);
        expect_run(256);

        // Three words with random valid gaps
        pulse_reload(8'h55);
        img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h0F0F;
        send_image(3, 8'h00, 1'b1);
        expect_run(3);

        // Abort after the first word, then load a one-word image
        pulse_reload(8'h00);
        send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        pulse_reload(8'h01);
        img[0] = 16'h5A5A;
        send_image(1, 8'h00, 1'b0);
        expect_run(1);

        // Reset in RUN together with reload
        @(negedge clk);
        rst = 1'b0; reload = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1; reload = 1'b0;
        @(negedge clk);
        pc = 16'h0000;
        #1;
        chk("rerst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rerst_loaded", 32'(loaded), 32'd0);
        chk("rerst_count", 32'(count), 32'd0);
        chk("rerst_error", 32'(error), 32'd0);
        chk("rerst_ready", 32'(in_ready), 32'd1);
        chk("rerst_instr", 32'(instruction), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
